io_uart_tx: RTL and testbench

Memory-mapped 8N1 UART transmitter on the IO side of `data_bus`, consuming `addr`, `ioWriteEnable` and the bidirectional `ioData` net. CPU stores push bytes into a small FIFO. A bit-timing FSM serialises the bytes onto `uartTx`. Status and divisor registers are readable over the same `ioData` net. The block is the first IO peripheral behind the bus's IO window (`addr[31:IO_BIT_COUNT] == 0`).

---
 rtl/io_uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_io_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the IO bus.
// A CPU store to TXDATA pushes a byte into a small FIFO. A bit-timing FSM
// serialises each byte LSB first onto uartTx as start, 8 data bits and stop.
// STATUS and DIV are read back combinationally over the shared ioData net.
module io_uart_tx #(
  parameter int                      IO_BIT_COUNT = 10,
  parameter logic [IO_BIT_COUNT-1:0] BASE_ADDR    = 'h020,
  parameter int                      FIFO_DEPTH   = 4,
  parameter logic [15:0]             DEFAULT_DIV  = 16'd434
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IO_BIT_COUNT-1:0] addr,
  input  logic                    ioWriteEnable,
  inout  wire  [31:0]             ioData,
  output logic                    uartTx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic w_sel, w_rd, w_push_req, w_div_wr, w_stat_wr;
  assign w_sel      = (addr[IO_BIT_COUNT-1:4] == BASE_ADDR[IO_BIT_COUNT-1:4]);
  assign w_rd       = w_sel & ~ioWriteEnable;
  assign w_push_req = w_sel & ioWriteEnable & (addr[3:2] == 2'd0);
  assign w_stat_wr  = w_sel & ioWriteEnable & (addr[3:2] == 2'd1);
  assign w_div_wr   = w_sel & ioWriteEnable & (addr[3:2] == 2'd2);

  // FIFO state
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_full, w_empty, w_pop, w_push_ok;
  logic [7:0]    w_head;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rptr];
  // A pop at the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push_req & (~w_full | w_pop);

  // Divisor register
  logic [15:0] r_div;

  // FSM state
  state_t      r_state, w_nxt_state;
  logic [15:0] r_timer, w_nxt_timer;
  logic [15:0] r_divl, w_nxt_divl;
  logic [7:0]  r_shift, w_nxt_shift;
  logic [2:0]  r_idx, w_nxt_idx;
  logic        r_tx, w_nxt_tx;
  logic        w_bit_end, w_busy;
  logic [15:0] w_reload;

  assign w_bit_end = (r_timer == 16'd0);
  assign w_reload  = r_divl - 16'd1;
  assign w_busy    = (r_state != S_IDLE) | ~w_empty;
  assign uartTx    = r_tx;

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= ioData[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_push_req & w_full & ~w_pop)  r_ovf <= 1'b1;
      else if (w_stat_wr & ioData[3])    r_ovf <= 1'b0;
    end
  end

  // DIV register; zero would stall the bit timer, so it is stored as 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_div <= DEFAULT_DIV;
    else if (w_div_wr) r_div <= (ioData[15:0] == 16'd0) ? 16'd1 : ioData[15:0];
  end

  // FSM registers; uartTx comes straight from a flop so the line never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_divl  <= DEFAULT_DIV;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_timer <= w_nxt_timer;
      r_divl  <= w_nxt_divl;
      r_shift <= w_nxt_shift;
      r_idx   <= w_nxt_idx;
      r_tx    <= w_nxt_tx;
    end
  end

  // Next-state logic; a pop from IDLE or end of STOP starts a new frame
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    w_nxt_divl  = r_divl;
    w_nxt_shift = r_shift;
    w_nxt_idx   = r_idx;
    w_nxt_tx    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_tx = 1'b1;
        w_pop    = ~w_empty;
      end
      S_START: begin
        if (w_bit_end) begin
          w_nxt_state = S_DATA;
          w_nxt_idx   = 3'd0;
          w_nxt_timer = w_reload;
          w_nxt_tx    = r_shift[0];
        end else begin
          w_nxt_timer = r_timer - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_nxt_timer = w_reload;
          if (r_idx == 3'd7) begin
            w_nxt_state = S_STOP;
            w_nxt_tx    = 1'b1;
          end else begin
            w_nxt_idx   = r_idx + 3'd1;
            w_nxt_shift = {1'b0, r_shift[7:1]};
            w_nxt_tx    = r_shift[1];
          end
        end else begin
          w_nxt_timer = r_timer - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (w_empty) begin
            w_nxt_state = S_IDLE;
            w_nxt_tx    = 1'b1;
          end else begin
            w_pop = 1'b1;
          end
        end else begin
          w_nxt_timer = r_timer - 16'd1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // Frame start: DIV is sampled here only, so mid-frame DIV writes wait a frame
    if (w_pop) begin
      w_nxt_shift = w_head;
      w_nxt_divl  = r_div;
      w_nxt_timer = r_div - 16'd1;
      w_nxt_state = S_START;
      w_nxt_tx    = 1'b0;
    end
  end

  // Register read mux
  logic [31:0] w_rdata;
  always_comb begin
    w_rdata = '0;
    case (addr[3:2])
      2'd1: begin
        w_rdata[0]      = w_busy;
        w_rdata[1]      = w_full;
        w_rdata[2]      = w_empty;
        w_rdata[3]      = r_ovf;
        w_rdata[8 +: CW] = r_count;
      end
      2'd2:    w_rdata[15:0] = r_div;
      default: w_rdata = '0;
    endcase
  end

  assign ioData = w_rd ? w_rdata : {32{1'bz}};

  logic w_unused;
  assign w_unused = &{1'b0, addr[1:0], ioData[31:16]};

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: bytes are queued as expected when stored, and
// popped and compared as each serial frame is decoded from uartTx.
module tb_io_uart_tx;
  localparam logic [9:0] A_TX = 10'h020;
  localparam logic [9:0] A_ST = 10'h024;
  localparam logic [9:0] A_DV = 10'h028;
  localparam logic [9:0] A_RS = 10'h02C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] drv = '0;
  logic        drv_en = 1'b0;
  wire  [31:0] ioData;
  wire         uartTx;

  assign ioData = drv_en ? drv : {32{1'bz}};

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb[$];

  io_uart_tx #(.IO_BIT_COUNT(10), .BASE_ADDR(10'h020), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .ioWriteEnable(we), .ioData(ioData), .uartTx(uartTx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // Bus store: called at a negedge, returns at the next negedge.
  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; drv = d; drv_en = 1'b1;
    @(negedge clk);
    we = 1'b0; drv_en = 1'b0; addr = '0;
  endtask

  // Bus load: combinational, consumes no clock edge.
  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    #1 d = ioData;
    addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Decode one frame sampled on negedges; first sample is the first start-bit cycle.
  task automatic capture(input int div, input bit chk_busy, output logic [7:0] data,
                         output int wcyc, output bit ok, output bit bsy_ok);
    logic v;
    data = 8'h00; ok = 1'b1; bsy_ok = 1'b1; wcyc = 0;
    while (uartTx !== 1'b0 && wcyc < 2000) begin @(negedge clk); wcyc++; end
    if (uartTx !== 1'b0) begin ok = 1'b0; return; end
    for (int b = 0; b < 10; b++) begin
      v = uartTx;
      for (int c = 0; c < div; c++) begin
        if (uartTx !== v) ok = 1'b0;
        if (chk_busy) begin
          addr = A_ST;
          #1 if (ioData[0] !== 1'b1) bsy_ok = 1'b0;
          addr = '0;
        end
        @(negedge clk);
      end
      if (b == 0 && v !== 1'b0) ok = 1'b0;
      else if (b == 9 && v !== 1'b1) ok = 1'b0;
      else if (b >= 1 && b <= 8) data[b-1] = v;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; addr = '0; we = 1'b0;
    idle(3);
    n_chk++; if (uartTx !== 1'b1) begin n_fail++; $display("FAIL rst_tx_hold got=%b exp=1", uartTx); end
    rst_n = 1'b1;
    idle(1);
    rd(A_ST, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL rst_status got=%h exp=%h", d, 32'h4); end
    rd(A_DV, d);
    n_chk++; if (d !== 32'd434) begin n_fail++; $display("FAIL rst_div got=%0d exp=434", d); end
    n_chk++; if (uartTx !== 1'b1) begin n_fail++; $display("FAIL rst_tx got=%b exp=1", uartTx); end
  endtask

  task automatic test_single();
    logic [31:0] d; logic [7:0] got, exp; int w; bit ok, bok;
    idle(1);
    wr(A_DV, 32'd4);
    rd(A_DV, d);
    n_chk++; if (d !== 32'd4) begin n_fail++; $display("FAIL single_div got=%0d exp=4", d); end
    wr(A_TX, 32'hA5); sb.push_back(8'hA5);
    n_chk++; if (uartTx !== 1'b1) begin n_fail++; $display("FAIL single_pre_tx got=%b exp=1", uartTx); end
    rd(A_ST, d);
    n_chk++; if (d !== 32'h101) begin n_fail++; $display("FAIL single_queued_status got=%h exp=%h", d, 32'h101); end
    capture(4, 1'b1, got, w, ok, bok);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (w !== 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=1", w); end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_shape got=bad exp=clean"); end
    n_chk++; if (!bok) begin n_fail++; $display("FAIL single_busy got=0 exp=1"); end
    n_chk++; if (got !== exp) begin n_fail++; $display("FAIL single_data got=%h exp=%h", got, exp); end
    rd(A_ST, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL single_end_status got=%h exp=%h", d, 32'h4); end
    n_chk++; if (uartTx !== 1'b1) begin n_fail++; $display("FAIL single_end_tx got=%b exp=1", uartTx); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [7:0] got, exp; int w; bit ok, bok;
    idle(1);
    wr(A_DV, 32'd2);
    wr(A_TX, 32'h00); sb.push_back(8'h00);
    wr(A_TX, 32'hFF); sb.push_back(8'hFF);
    for (int f = 0; f < 2; f++) begin
      capture(2, 1'b0, got, w, ok, bok);
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      n_chk++; if (w !== 0) begin n_fail++; $display("FAIL b2b_gap%0d got=%0d exp=0", f, w); end
      n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_shape%0d got=bad exp=clean", f); end
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL b2b_data%0d got=%h exp=%h", f, got, exp); end
      rd(A_ST, d);
      n_chk++; if (d !== ((f == 0) ? 32'h5 : 32'h4)) begin
        n_fail++; $display("FAIL b2b_status%0d got=%h exp=%h", f, d, (f == 0) ? 32'h5 : 32'h4);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] d; logic [7:0] got, exp; int w; bit ok, bok;
    idle(1);
    wr(A_DV, 32'd2);
    wr(A_TX, 32'h11);
    for (int i = 2; i <= 5; i++) begin
      wr(A_TX, 32'(8'h11 * i)); sb.push_back(8'(8'h11 * i));
    end
    rd(A_ST, d);
    n_chk++; if (d !== 32'h403) begin n_fail++; $display("FAIL fp_full_status got=%h exp=%h", d, 32'h403); end
    // Land the next store exactly on the edge that ends the first frame.
    idle(16);
    wr(A_TX, 32'h66); sb.push_back(8'h66);
    rd(A_ST, d);
    n_chk++; if (d !== 32'h403) begin n_fail++; $display("FAIL fp_accept_status got=%h exp=%h", d, 32'h403); end
    for (int f = 0; f < 5; f++) begin
      capture(2, 1'b0, got, w, ok, bok);
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      n_chk++; if (w !== 0) begin n_fail++; $display("FAIL fp_gap%0d got=%0d exp=0", f, w); end
      n_chk++; if (!ok) begin n_fail++; $display("FAIL fp_shape%0d got=bad exp=clean", f); end
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL fp_data%0d got=%h exp=%h", f, got, exp); end
    end
    rd(A_ST, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL fp_end_status got=%h exp=%h", d, 32'h4); end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic [7:0] got, exp; int w; bit ok, bok, hi;
    idle(1);
    wr(A_DV, 32'd100);
    for (int i = 1; i <= 6; i++) begin
      wr(A_TX, 32'(i));
      if (i >= 2 && i <= 5) sb.push_back(8'(i));
    end
    rd(A_ST, d);
    n_chk++; if (d !== 32'h40B) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", d, 32'h40B); end
    wr(A_ST, 32'h8);
    rd(A_ST, d);
    n_chk++; if (d !== 32'h403) begin n_fail++; $display("FAIL ovf_clear got=%h exp=%h", d, 32'h403); end
    // Skip the rest of the in-flight 0x01 frame to land on the next start bit.
    idle(995);
    for (int f = 0; f < 4; f++) begin
      capture(100, 1'b0, got, w, ok, bok);
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      n_chk++; if (w !== 0) begin n_fail++; $display("FAIL ovf_gap%0d got=%0d exp=0", f, w); end
      n_chk++; if (!ok) begin n_fail++; $display("FAIL ovf_shape%0d got=bad exp=clean", f); end
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL ovf_data%0d got=%h exp=%h", f, got, exp); end
    end
    hi = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (uartTx !== 1'b1) hi = 1'b0;
      @(negedge clk);
    end
    n_chk++; if (!hi) begin n_fail++; $display("FAIL ovf_dropped_sent got=frame exp=idle"); end
    rd(A_ST, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL ovf_end_status got=%h exp=%h", d, 32'h4); end
  endtask

  task automatic test_div();
    logic [31:0] d; logic [7:0] got, exp; int w; bit ok, bok;
    idle(1);
    wr(A_DV, 32'd0);
    rd(A_DV, d);
    n_chk++; if (d !== 32'd1) begin n_fail++; $display("FAIL div0_read got=%0d exp=1", d); end
    wr(A_TX, 32'h55); sb.push_back(8'h55);
    capture(1, 1'b1, got, w, ok, bok);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (w !== 1) begin n_fail++; $display("FAIL div1_latency got=%0d exp=1", w); end
    n_chk++; if (!ok || !bok) begin n_fail++; $display("FAIL div1_shape got=%b%b exp=11", ok, bok); end
    n_chk++; if (got !== exp) begin n_fail++; $display("FAIL div1_data got=%h exp=%h", got, exp); end
    rd(A_ST, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL div1_status got=%h exp=%h", d, 32'h4); end
    wr(A_DV, 32'd4);
    wr(A_TX, 32'h3C); sb.push_back(8'h3C);
    wr(A_TX, 32'hC3); sb.push_back(8'hC3);
    fork
      capture(4, 1'b0, got, w, ok, bok);
      begin idle(10); wr(A_DV, 32'd8); end
    join
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (w !== 0 || !ok) begin n_fail++; $display("FAIL divchg_frame1 got=w%0d ok%b exp=w0 ok1", w, ok); end
    n_chk++; if (got !== exp) begin n_fail++; $display("FAIL divchg_data1 got=%h exp=%h", got, exp); end
    capture(8, 1'b0, got, w, ok, bok);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (w !== 0 || !ok) begin n_fail++; $display("FAIL divchg_frame2 got=w%0d ok%b exp=w0 ok1", w, ok); end
    n_chk++; if (got !== exp) begin n_fail++; $display("FAIL divchg_data2 got=%h exp=%h", got, exp); end
    rd(A_DV, d);
    n_chk++; if (d !== 32'd8) begin n_fail++; $display("FAIL divchg_read got=%0d exp=8", d); end
  endtask

  task automatic test_bus();
    logic [31:0] d;
    logic [9:0] na [4];
    na[0] = 10'h000; na[1] = 10'h004; na[2] = 10'h030; na[3] = 10'h034;
    idle(1);
    // Bench drives a pattern; any DUT drive on top of it corrupts the readback.
    drv = 32'hA5A5_5A5A; drv_en = 1'b1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = na[i];
      #1 n_chk++;
      if (ioData !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL bus_unsel_%h got=%h exp=%h", na[i], ioData, 32'hA5A5_5A5A); end
    end
    addr = '0; drv_en = 1'b0;
    idle(1);
    drv = 32'hA5A5_5A52; drv_en = 1'b1; addr = A_ST; we = 1'b1;
    #1 n_chk++;
    if (ioData !== 32'hA5A5_5A52) begin n_fail++; $display("FAIL bus_we_drive got=%h exp=%h", ioData, 32'hA5A5_5A52); end
    we = 1'b0; drv_en = 1'b0; addr = '0;
    idle(1);
    rd(A_ST + 10'd2, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL bus_lowbits got=%h exp=%h", d, 32'h4); end
    rd(A_TX, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL bus_txdata_read got=%h exp=0", d); end
    rd(A_RS, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL bus_rsvd_read got=%h exp=0", d); end
    idle(1);
    wr(A_RS, 32'hFFFF_FFFF);
    rd(A_ST, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL bus_rsvd_wr_status got=%h exp=%h", d, 32'h4); end
    rd(A_DV, d);
    n_chk++; if (d !== 32'd8) begin n_fail++; $display("FAIL bus_rsvd_wr_div got=%0d exp=8", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; bit hi;
    idle(1);
    wr(A_DV, 32'd4);
    wr(A_TX, 32'hF0);
    wr(A_TX, 32'h33);
    idle(5);
    n_chk++; if (uartTx !== 1'b0) begin n_fail++; $display("FAIL rm_bit0 got=%b exp=0", uartTx); end
    rst_n = 1'b0;
    #1 n_chk++;
    if (uartTx !== 1'b1) begin n_fail++; $display("FAIL rm_async_tx got=%b exp=1", uartTx); end
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rd(A_ST, d);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL rm_status got=%h exp=%h", d, 32'h4); end
    rd(A_DV, d);
    n_chk++; if (d !== 32'd434) begin n_fail++; $display("FAIL rm_div got=%0d exp=434", d); end
    hi = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (uartTx !== 1'b1) hi = 1'b0;
      @(negedge clk);
    end
    n_chk++; if (!hi) begin n_fail++; $display("FAIL rm_fifo_discard got=frame exp=idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_overflow();
    test_div();
    test_bus();
    test_reset_mid();
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
